uart_rx_core: RTL
=================

# uart_rx_core

Receive-side UART core. It samples the serial `rx` line driven by the UART agent interface and recovers 8N1 / 8E1 / 8O1 frames with a fixed clocks-per-bit divider. It checks framing and parity, and pushes good bytes into a small first-word-fall-through FIFO with a valid/ready read port. It sits directly downstream of the agent's `rx` wire and feeds the register or bus layer of the UART DUT.

## Interface
- `CLKS_PER_BIT`, 16: clk cycles per bit period; even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..8, sent LSB first.
- `PARITY_EN`, 0: 1 means a parity bit follows the data.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `rx`  in  1  raw serial input; asynchronous; idles high.
- `rx_data`  out  DATA_BITS  FIFO head byte; valid while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer pop; a pop occurs when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, both reset to 1. The FSM uses only the synchronized value `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK. A bit counter of width $clog2(CLKS_PER_BIT) and a bit index drive the transitions.
- **IDLE:** `rxs`=0 moves to START and clears the counter.
- **START:**
  - At counter = CLKS_PER_BIT/2−1, sample `rxs`.
  - 1 means a glitch: return to IDLE with no error.
  - 0 means a valid start: move to DATA, counter reset.
- **DATA:**
  - Sample `rxs` at counter = CLKS_PER_BIT−1 (mid-bit) and shift it into bit[index], LSB first.
  - After DATA_BITS samples, go to PARITY if `PARITY_EN`, otherwise STOP.
- **PARITY:**
  - Sample once at mid-bit.
  - Expected value is XOR(data) for even parity, ~XOR(data) for odd.
  - A mismatch sets an internal flag. Go to STOP.
- **STOP:** sample at mid-bit. Then:
  - `rxs`=0: pulse `frame_err` and discard the byte. Go to BREAK. `parity_err` is not reported for this frame.
  - `rxs`=1 with the parity flag set: pulse `parity_err`, discard the byte, go to IDLE.
  - `rxs`=1 and good: push into the FIFO, go to IDLE. If the FIFO is full and not popping in the same cycle, pulse `overrun` instead and drop the new byte; FIFO contents stay unchanged.
- **BREAK:** wait for `rxs`=1, then go to IDLE. This prevents a line held low from re-triggering a start.
- **FIFO:**
  - Circular buffer with wrapping read/write pointers and a count of $clog2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle are both honoured and the count is unchanged. This holds when full: the pop frees a slot, so there is no overrun. It also holds when empty only if the push targets an already-valid head, so when empty a pop cannot occur.
  - `rx_data` is held stable while `rx_valid`=1 and no pop occurs.
- **Reset, asserted at any time (including mid-frame):**
  - FSM goes to IDLE and counters clear.
  - FIFO empties and the partial byte is lost.
  - Synchronizer goes to 1.
  - All outputs go to 0 (`rx_data`=0).

## Timing
- Let E be the first rising edge with raw `rx`=0. `rxs` goes low after E+1, and IDLE→START occurs at E+2.
- Mid-start sample is at E+2+CLKS_PER_BIT/2.
- The k-th data sample (k=0..DATA_BITS−1) is at E+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- The stop sample S is at E+2+CLKS_PER_BIT/2+(DATA_BITS+PARITY_EN+1)·CLKS_PER_BIT.
- The FIFO write happens at edge S. `rx_valid` and the new `rx_data` are visible after S (from cycle S+1).
- Error and overrun pulses are high for exactly the cycle following edge S.
- The FSM is back in IDLE after S, so a new start bit that begins half a bit later is accepted.
- Back-to-back frames with zero idle are supported.
- `busy` is 1 from the cycle after the IDLE→START edge through the cycle of edge S.

## Test plan
- **Single byte:** default parameters, 8N1, send 0xA5 with 16-cycle bits. Expect `rx_valid` rising 2+8+144 cycles after E, `rx_data`=0xA5, and no error pulses. Pop with `rx_ready`=1; `rx_valid` then drops.
- **Glitch:** `rx` low for 4 cycles, then high. Expect the FSM to return to IDLE, no `rx_valid`, no errors. A following 0x3C frame is received correctly.
- **Parity:** `PARITY_EN`=1, even. Send 0x07 with parity bit 1, then 0x07 with parity bit 0. Expect the first byte stored. The second produces a `parity_err` pulse and nothing is stored.
- **Framing / break:** send 0x55 with stop=0, then hold `rx` low for 40 cycles before releasing. Expect exactly one `frame_err` pulse, no FIFO push, and no spurious start while low. A following 0x11 is received correctly.
- **Full / overrun / wrap:** `rx_ready`=0, send 0x01..0x05 back-to-back. Expect FIFO holding 0x01..0x04 and one `overrun` on 0x05. Then drain and send 6 more with `rx_ready`=1. Expect in-order delivery across pointer wrap. Finally a full FIFO with a pop on the S cycle: the byte is accepted and there is no overrun.
- **Reset mid-frame:** assert `rst` low at data bit 3 with 2 bytes queued. Expect all outputs 0 and `busy`=0. After release, 0x9E is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM with optional parity,
// and a first-word-fall-through receive FIFO with a valid/ready read port.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge on rxs
  // START  | timing to mid start bit to reject glitches
  // DATA   | sampling data bits LSB first at mid-bit
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit, push / error decision
  // BREAK  | line stuck low after a framing error, wait for high
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  state_t               state;
  logic                 rx_m, rxs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_flag;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [NW-1:0]        count;
  logic                 full, pop, push, wr_en, mid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  assign mid      = (cnt == FULL);
  assign rx_valid = (count != '0);
  assign full     = (count == NW'(FIFO_DEPTH));
  assign pop      = rx_valid && rx_ready;
  assign push     = (state == STOP) && mid && rxs && !par_flag;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en    = push && (!full || pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_flag   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= DATA;
              idx      <= '0;
              par_flag <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (mid) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            idx        <= idx + IW'(1);
            if (idx == LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: begin
          if (mid) begin
            cnt      <= '0;
            par_flag <= rxs ^ (^shreg) ^ (PARITY_ODD != 0);
            state    <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (mid) begin
            cnt <= '0;
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (par_flag)          parity_err <= 1'b1;
              else if (full && !pop) overrun    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
